// File: rtl/ll1_downsample2x2.sv
// Streaming 2x2 box-filter decimator: averages each non-overlapping 2x2 block of a raster frame.
// Optional macro LL1_DS_ROUND_EN selects round-half-up averaging instead of truncation.
module ll1_downsample2x2 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] In1_DATA,
  input  logic [15:0] In1_COUNT,
  input  logic        In1_SEND,
  output logic        In1_ACK,
  output logic [15:0] Out1_DATA,
  output logic [15:0] Out1_COUNT,
  output logic        Out1_SEND,
  input  logic        Out1_RDY,
  input  logic        Out1_ACK
);

  localparam int CW       = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW       = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_t;

  row_state_t    r_state;
  row_state_t    w_state_next;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [15:0]   r_hold_px;
  logic          r_full;
  logic [15:0]   r_out_data;
  logic [16:0]   r_linebuf [LB_DEPTH];
  logic [16:0]   r_lb_rd;

  logic          w_accept;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_odd_col;
  logic [AW-1:0] w_lb_addr;
  logic [16:0]   w_pairsum;
  logic [17:0]   w_sum;
  logic [15:0]   w_avg;
  logic          w_unused;

  assign w_unused   = ^{In1_COUNT, Out1_ACK};

  assign w_accept   = In1_SEND & ~r_full;
  assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));
  assign w_odd_col  = r_col[0];
  assign w_lb_addr  = AW'(r_col >> 1);

  assign w_pairsum  = {1'b0, r_hold_px} + {1'b0, In1_DATA};
  assign w_sum      = {1'b0, r_lb_rd} + {2'b00, r_hold_px} + {2'b00, In1_DATA};

`ifdef LL1_DS_ROUND_EN
  logic [17:0] w_sum_rnd;
  assign w_sum_rnd = w_sum + 18'd2;
  assign w_avg     = w_sum_rnd[17:2];
`else
  assign w_avg     = w_sum[17:2];
`endif

  // Read is launched on the even-col accept so the pair sum is waiting at the odd-col accept.
  always_ff @(posedge CLK) begin
    if (w_accept && !w_odd_col) begin
      r_lb_rd <= r_linebuf[w_lb_addr];
    end
    if (w_accept && w_odd_col && (r_state == ROW_EVEN)) begin
      r_linebuf[w_lb_addr] <= w_pairsum;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ROW_EVEN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept && w_col_last) begin
      w_state_next = (r_state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_col      <= '0;
      r_row      <= '0;
      r_hold_px  <= 16'h0;
      r_full     <= 1'b0;
      r_out_data <= 16'h0;
    end else begin
      if (Out1_SEND) begin
        r_full <= 1'b0;
      end
      if (w_accept) begin
        if (!w_odd_col) begin
          r_hold_px <= In1_DATA;
        end else if (r_state == ROW_ODD) begin
          r_out_data <= w_avg;
          r_full     <= 1'b1;
        end
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign In1_ACK    = w_accept;
  assign Out1_SEND  = r_full & Out1_RDY;
  assign Out1_DATA  = r_out_data;
  assign Out1_COUNT = 16'h0001;

endmodule

// File: tb/tb_ll1_downsample2x2.sv
// Bench for ll1_downsample2x2: a 4x2 instance for most scenarios and a 4x4 instance for frame wrap.
module tb_ll1_downsample2x2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       in_send;
  logic [1:0]       out_rdy;
  logic [1:0][15:0] in_data;
  wire  [1:0]       in_ack;
  wire  [1:0]       out_send;
  wire  [1:0][15:0] out_data;
  wire  [1:0][15:0] out_count;

  int n_total = 0;
  int n_pass  = 0;

`ifdef LL1_DS_ROUND_EN
  localparam int E_B0 = 4;
  localparam int E_B1 = 6;
  localparam int E_T1 = 2;
`else
  localparam int E_B0 = 3;
  localparam int E_B1 = 5;
  localparam int E_T1 = 1;
`endif
  localparam int E_T0 = 3;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Hand-computed averages of the 4x4 ramp 1..16.
  function automatic int wrap_exp(input int k);
`ifdef LL1_DS_ROUND_EN
    case (k) 0: return 4; 1: return 6; 2: return 12; default: return 14; endcase
`else
    case (k) 0: return 3; 1: return 5; 2: return 11; default: return 13; endcase
`endif
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int W = 4;
      localparam int H = (gi == 0) ? 2 : 4;

      ll1_downsample2x2 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (
        .CLK        (clk),
        .RESET      (rst_n),
        .In1_DATA   (in_data[gi]),
        .In1_COUNT  (16'h0001),
        .In1_SEND   (in_send[gi]),
        .In1_ACK    (in_ack[gi]),
        .Out1_DATA  (out_data[gi]),
        .Out1_COUNT (out_count[gi]),
        .Out1_SEND  (out_send[gi]),
        .Out1_RDY   (out_rdy[gi]),
        .Out1_ACK   (out_send[gi])
      );

      // Model: store accepted pixels in a frame image, emit the block average when a block completes.
      logic [15:0] frame [H][W];
      logic [15:0] log_q [$];
      int          exp_q [$];
      int          m_col;
      int          m_row;

      initial begin
        int s;
        int e;
        m_col = 0;
        m_row = 0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            m_col = 0;
            m_row = 0;
            exp_q.delete();
          end else begin
            if (out_send[gi]) begin
              log_q.push_back(out_data[gi]);
              e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
              chk("out_data", int'(out_data[gi]), e);
              chk("out_count", int'(out_count[gi]), 1);
              $display("dut%0d out data=%0d expected=%0d", gi, out_data[gi], e);
            end
            if (in_send[gi] && in_ack[gi]) begin
              frame[m_row][m_col] = in_data[gi];
              if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
                s = int'(frame[m_row-1][m_col-1]) + int'(frame[m_row-1][m_col]) +
                    int'(frame[m_row][m_col-1]) + int'(frame[m_row][m_col]);
`ifdef LL1_DS_ROUND_EN
                exp_q.push_back((s + 2) / 4);
`else
                exp_q.push_back(s / 4);
`endif
              end
              if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
              end else begin
                m_col++;
              end
            end
          end
        end
      end
    end
  endgenerate

  // Tasks enter and leave just after a rising edge.
  task automatic send_px(input int d, input logic [15:0] px);
    int t;
    t = 0;
    in_data[d] = px;
    in_send[d] = 1'b1;
    @(negedge clk);
    while (!in_ack[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ack[d]) chk("ack_timeout", t, 0);
    @(posedge clk);
    #1;
    in_send[d] = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int ack_seen;
    int vals [8];
    rst_n   = 1'b0;
    in_send = '0;
    out_rdy = 2'b11;
    in_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_send", int'(out_send[0]), 0);
    chk("rst_ack", int'(in_ack[0]), 0);
    chk("rst_data", int'(out_data[0]), 0);
    chk("rst_count", int'(out_count[0]), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic ramp 1..8
    g_dut[0].log_q.delete();
    for (int i = 1; i <= 8; i++) send_px(0, 16'(i));
    settle();
    chk("basic_n", g_dut[0].log_q.size(), 2);
    chk("basic_0", int'(g_dut[0].log_q[0]), E_B0);
    chk("basic_1", int'(g_dut[0].log_q[1]), E_B1);

    // Saturation
    g_dut[0].log_q.delete();
    for (int i = 0; i < 8; i++) send_px(0, 16'hFFFF);
    settle();
    chk("sat_n", g_dut[0].log_q.size(), 2);
    chk("sat_0", int'(g_dut[0].log_q[0]), 65535);
    chk("sat_1", int'(g_dut[0].log_q[1]), 65535);

    // Backpressure: block 10,20,50,60 -> 35 held while Out1_RDY=0
    g_dut[0].log_q.delete();
    out_rdy[0] = 1'b0;
    vals = '{10, 20, 30, 40, 50, 60, 70, 80};
    for (int i = 0; i < 6; i++) send_px(0, 16'(vals[i]));
    in_data[0] = 16'd70;
    in_send[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_send", int'(out_send[0]), 0);
      chk("bp_ack", int'(in_ack[0]), 0);
      chk("bp_data", int'(out_data[0]), 35);
    end
    @(posedge clk);
    #1;
    out_rdy[0] = 1'b1;
    pulses   = 0;
    ack_seen = 0;
    for (int t = 0; t < 10 && ack_seen == 0; t++) begin
      @(negedge clk);
      if (out_send[0]) pulses++;
      if (in_ack[0]) ack_seen = 1;
    end
    chk("bp_pulses", pulses, 1);
    chk("bp_ack_resume", ack_seen, 1);
    @(posedge clk);
    #1;
    in_send[0] = 1'b0;
    send_px(0, 16'd80);
    settle();
    chk("bp_n", g_dut[0].log_q.size(), 2);
    chk("bp_0", int'(g_dut[0].log_q[0]), 35);
    chk("bp_1", int'(g_dut[0].log_q[1]), 55);

    // Reset with an output pending
    out_rdy[0] = 1'b0;
    for (int i = 1; i <= 6; i++) send_px(0, 16'(i * 100));
    rst_n      = 1'b0;
    out_rdy[0] = 1'b1;
    #1;
    chk("rst_async_send", int'(out_send[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    g_dut[0].log_q.delete();
    for (int i = 1; i <= 8; i++) send_px(0, 16'(i));
    settle();
    chk("rstmid_n", g_dut[0].log_q.size(), 2);
    chk("rstmid_0", int'(g_dut[0].log_q[0]), E_B0);
    chk("rstmid_1", int'(g_dut[0].log_q[1]), E_B1);

    // Rounding ties: blocks 3,3,3,4 and 1,1,1,3
    g_dut[0].log_q.delete();
    vals = '{3, 3, 1, 1, 3, 4, 1, 3};
    for (int i = 0; i < 8; i++) send_px(0, 16'(vals[i]));
    settle();
    chk("tie_n", g_dut[0].log_q.size(), 2);
    chk("tie_0", int'(g_dut[0].log_q[0]), E_T0);
    chk("tie_1", int'(g_dut[0].log_q[1]), E_T1);

    // Two back-to-back 4x4 frames
    g_dut[1].log_q.delete();
    for (int f = 0; f < 2; f++)
      for (int i = 1; i <= 16; i++) send_px(1, 16'(i));
    settle();
    chk("wrap_n", g_dut[1].log_q.size(), 8);
    for (int k = 0; k < 8; k++) chk("wrap_val", int'(g_dut[1].log_q[k]), wrap_exp(k % 4));

    chk("q0_drained", g_dut[0].exp_q.size(), 0);
    chk("q1_drained", g_dut[1].exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
